// File: rtl/ps2_init_sequencer_pkg.sv
// ps2_init_sequencer_pkg: PS/2 command/response bytes and bring-up state encoding
package ps2_init_sequencer_pkg;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RSP_BAT_FAIL = 8'hFC;
  typedef enum logic [3:0] {
    POWER_WAIT, SEND_RST, WAIT_ACK, WAIT_BAT, SEND_LED_CMD,
    WAIT_LED_ACK, SEND_LED_VAL, WAIT_VAL_ACK, DONE, ERROR
  } state_t;
endpackage

// File: rtl/ps2_init_sequencer_init_timer.sv
// ps2_init_sequencer_init_timer: clearable up-counter flagging when it holds TERMINAL
module ps2_init_sequencer_init_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clear ? '0 : count + 1'b1;
  assign done = count == WIDTH'(TERMINAL);
endmodule

// File: rtl/ps2_init_sequencer.sv
// ps2_init_sequencer: keyboard bring-up (reset, BAT check, LED programming)
// with resend handling, response timeouts and a bounded retry budget.
module ps2_init_sequencer
  import ps2_init_sequencer_pkg::*;
#(
  parameter int WAIT_COUNT    = 15,
  parameter int WAIT_WIDTH    = 4,
  parameter int ACK_TIMEOUT   = 255,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_WIDTH   = 2,
  parameter int SET_LEDS      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_required,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  input  logic [2:0]             led_state,
  output logic                   init_busy,
  output logic                   init_done,
  output logic                   init_error,
  output logic [RETRY_WIDTH-1:0] retry_count
);
  state_t state, state_next, ok_state, resend_state;
  logic pw_done, to_done, xfer, in_wait, got, resend, fail, retry, give_up;
  logic tx_valid_d, init_busy_d, init_done_d, init_error_d;
  logic [7:0] tx_byte_d, expect_byte;
  logic [2:0] led_val, led_val_next;
  logic [RETRY_WIDTH-1:0] retry_next;

  assign xfer    = tx_valid && tx_ready;
  assign in_wait = state inside {WAIT_ACK, WAIT_BAT, WAIT_LED_ACK, WAIT_VAL_ACK};

  ps2_init_sequencer_init_timer #(.WIDTH(WAIT_WIDTH), .TERMINAL(WAIT_COUNT)) u_power (
    .clk(clk), .rst(rst), .clear(state != POWER_WAIT || reset_required), .done(pw_done));
  // each response byte gets a fresh window: clear whenever the state changes
  ps2_init_sequencer_init_timer #(.WIDTH(TIMEOUT_WIDTH), .TERMINAL(ACK_TIMEOUT)) u_resp (
    .clk(clk), .rst(rst), .clear(!in_wait || state_next != state), .done(to_done));

  always_comb begin
    expect_byte  = PS2_RSP_ACK;
    ok_state     = DONE;
    resend_state = SEND_RST;
    case (state)
      WAIT_ACK: ok_state = WAIT_BAT;
      WAIT_BAT: begin
        expect_byte = PS2_RSP_BAT_OK;
        ok_state    = SET_LEDS != 0 ? SEND_LED_CMD : DONE;
      end
      WAIT_LED_ACK: begin
        ok_state     = SEND_LED_VAL;
        resend_state = SEND_LED_CMD;
      end
      WAIT_VAL_ACK: resend_state = SEND_LED_VAL;
      default: ;
    endcase
  end

  assign got     = in_wait && rx_valid && rx_byte == expect_byte;
  assign resend  = in_wait && rx_valid && rx_byte == PS2_RSP_RESEND;
  assign fail    = (state == WAIT_BAT && rx_valid && rx_byte == PS2_RSP_BAT_FAIL) || (in_wait && to_done);
  assign retry   = !got && (resend || fail);
  assign give_up = retry_count == RETRY_WIDTH'(MAX_RETRIES);

  always_comb begin
    state_next = state;
    case (state)
      POWER_WAIT:   state_next = pw_done ? SEND_RST : POWER_WAIT;
      SEND_RST:     state_next = xfer ? WAIT_ACK : SEND_RST;
      SEND_LED_CMD: state_next = xfer ? WAIT_LED_ACK : SEND_LED_CMD;
      SEND_LED_VAL: state_next = xfer ? WAIT_VAL_ACK : SEND_LED_VAL;
      DONE:         state_next = (SET_LEDS != 0 && led_state != led_val) ? SEND_LED_CMD : DONE;
      ERROR:        state_next = ERROR;
      default:      state_next = got ? ok_state : !retry ? state : give_up ? ERROR :
                                 resend ? resend_state : SEND_RST;
    endcase
    if (reset_required) state_next = POWER_WAIT;
  end

  always_comb begin
    led_val_next = (state == WAIT_LED_ACK && state_next == SEND_LED_VAL) ? led_state : led_val;
    retry_next   = (reset_required || (state == DONE && state_next == SEND_LED_CMD)) ? '0 :
                   (retry && !give_up) ? retry_count + 1'b1 : retry_count;
    tx_valid_d   = state_next inside {SEND_RST, SEND_LED_CMD, SEND_LED_VAL};
    tx_byte_d    = state_next == SEND_RST     ? PS2_CMD_RESET :
                   state_next == SEND_LED_CMD ? PS2_CMD_SET_LEDS :
                   state_next == SEND_LED_VAL ? {5'b0, led_val_next} : tx_byte;
    init_busy_d  = !(state_next inside {DONE, ERROR});
    init_error_d = state_next == ERROR;
    init_done_d  = !reset_required && (init_done || state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= POWER_WAIT;
      led_val     <= '0;
      retry_count <= '0;
      tx_valid    <= 1'b0;
      tx_byte     <= 8'h00;
      init_busy   <= 1'b1;
      init_done   <= 1'b0;
      init_error  <= 1'b0;
    end else begin
      state       <= state_next;
      led_val     <= reset_required ? 3'b0 : led_val_next;
      retry_count <= retry_next;
      tx_valid    <= tx_valid_d;
      tx_byte     <= tx_byte_d;
      init_busy   <= init_busy_d;
      init_done   <= init_done_d;
      init_error  <= init_error_d;
    end
endmodule

// File: tb/tb_ps2_init_sequencer.sv
// tb_ps2_init_sequencer: directed bring-up scenarios plus random soak, all checked
// every cycle against a script-driven keyboard-handshake model.
module tb_ps2_init_sequencer;
  localparam int WC = 15, AT = 31, MR = 2;
  localparam int PW = 0, SND = 1, WT = 2, DN = 3, ER = 4;
  logic clk = 0, rst = 1, reset_required = 0, rx_valid = 0, tx_ready = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [2:0] led_state = 3'b000;
  logic tx_valid, init_busy, init_done, init_error;
  logic [7:0] tx_byte;
  logic [1:0] retry_count;
  int total = 0, bad = 0;
  int n, pulses, low, r;
  int m_mode, m_step, m_cnt, m_retry, m_done;
  logic [7:0] m_txb;
  logic [2:0] m_led;
  logic [7:0] pick [5];

  always #5 clk = ~clk;

  ps2_init_sequencer #(.WAIT_COUNT(WC), .WAIT_WIDTH(4), .ACK_TIMEOUT(AT), .TIMEOUT_WIDTH(5),
                       .MAX_RETRIES(MR), .RETRY_WIDTH(2), .SET_LEDS(1)) dut (
    .clk(clk), .rst(rst), .reset_required(reset_required), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .led_state(led_state), .init_busy(init_busy), .init_done(init_done),
    .init_error(init_error), .retry_count(retry_count));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // script steps: 0 send FF/await FA, 1 await AA, 2 send ED/await FA, 3 send leds/await FA
  task automatic go_send(int s);
    m_mode = SND;
    m_step = s;
    m_txb  = s == 0 ? 8'hFF : s == 2 ? 8'hED : {5'b0, m_led};
  endtask

  task automatic model_reset();
    m_mode = PW; m_step = 0; m_cnt = 0; m_retry = 0; m_done = 0; m_txb = 8'h00; m_led = 3'b0;
  endtask

  task automatic model_step();
    logic [7:0] want;
    logic got, rs, fl;
    if (reset_required) begin
      m_mode = PW; m_cnt = 0; m_retry = 0; m_done = 0; m_led = 3'b0;
      return;
    end
    case (m_mode)
      PW: begin
        m_cnt++;
        if (m_cnt == WC + 1) go_send(0);
      end
      SND: if (tx_ready) begin m_mode = WT; m_cnt = 0; end
      WT: begin
        m_cnt++;
        want = m_step == 1 ? 8'hAA : 8'hFA;
        got  = rx_valid && rx_byte == want;
        rs   = rx_valid && rx_byte == 8'hFE;
        fl   = (m_step == 1 && rx_valid && rx_byte == 8'hFC) || m_cnt > AT;
        if (got) begin
          if (m_step == 0) begin m_step = 1; m_cnt = 0; end
          else if (m_step == 1) go_send(2);
          else if (m_step == 2) begin m_led = led_state; go_send(3); end
          else begin m_mode = DN; m_done = 1; end
        end else if (rs || fl) begin
          if (m_retry == MR) m_mode = ER;
          else begin m_retry++; go_send(rs ? (m_step < 2 ? 0 : m_step) : 0); end
        end
      end
      DN: if (led_state != m_led) begin m_retry = 0; go_send(2); end
      default: ;
    endcase
  endtask

  task automatic tick();
    logic [13:0] exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp = {m_mode == SND, m_txb, !(m_mode == DN || m_mode == ER), m_done[0], m_mode == ER, m_retry[1:0]};
    check("cycle", {tx_valid, tx_byte, init_busy, init_done, init_error, retry_count}, exp);
  endtask

  task automatic send_rx(logic [7:0] b);
    rx_valid = 1; rx_byte = b;
    tick();
    rx_valid = 0;
  endtask

  task automatic pulse_rr();
    reset_required = 1;
    tick();
    reset_required = 0;
  endtask

  task automatic wait_tx(string nm, int exp_n);
    n = 0;
    while (!tx_valid && n < 60) begin tick(); n++; end
    check(nm, n, exp_n);
  endtask

  task automatic finish_bring_up();
    tick();
    send_rx(8'hFA);
    send_rx(8'hAA);
    tick();
    send_rx(8'hFA);
    tick();
    send_rx(8'hFA);
  endtask

  initial begin
    pick[0] = 8'hFA; pick[1] = 8'hAA; pick[2] = 8'hFE; pick[3] = 8'hFC; pick[4] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_outputs", {tx_valid, tx_byte, init_busy, init_done, init_error, retry_count}, 14'b0_00000000_1_0_0_00);
    rst = 0;
    tx_ready = 1; led_state = 3'b101;
    // nominal bring-up
    wait_tx("powerup_edges", 16);
    check("first_byte", tx_byte, 8'hFF);
    tick();
    send_rx(8'hFA);
    send_rx(8'hAA);
    check("led_cmd", {tx_valid, tx_byte}, 9'h1ED);
    tick();
    send_rx(8'hFA);
    check("led_val", {tx_valid, tx_byte}, 9'h105);
    tick();
    send_rx(8'hFA);
    check("nominal_done", {init_done, init_busy, retry_count}, 4'b1000);
    // resend of the reset command
    pulse_rr();
    wait_tx("rr_restart", 16);
    tick();
    send_rx(8'hFE);
    check("resend_byte", {tx_valid, tx_byte, retry_count}, 11'b1_11111111_01);
    finish_bring_up();
    check("resend_done", {init_done, retry_count}, 3'b101);
    // backpressure, then reset_required while waiting for BAT
    pulse_rr();
    tx_ready = 0;
    wait_tx("bp_restart", 16);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {tx_valid, tx_byte}, 9'h1FF);
    end
    tx_ready = 1;
    tick();
    check("bp_xfer", tx_valid, 1'b0);
    send_rx(8'hFE);
    tick();
    send_rx(8'hFA);
    repeat (3) tick();
    check("bat_retry", retry_count, 2'd1);
    pulse_rr();
    check("rr_bat", {tx_valid, init_busy, retry_count}, 4'b0100);
    wait_tx("rr_bat_restart", 16);
    // timeouts until the retry budget runs out
    pulses = 0; low = 0;
    for (int i = 0; i < 200 && !init_error; i++) begin
      if (tx_valid) begin
        if (pulses > 0) check("timeout_gap", low, AT + 1);
        pulses++; low = 0;
      end else low++;
      tick();
    end
    check("timeout_pulses", pulses, 3);
    check("error_flags", {init_error, init_busy, retry_count}, 4'b1010);
    pulse_rr();
    check("error_cleared", {init_error, init_busy}, 2'b01);
    wait_tx("err_restart", 16);
    finish_bring_up();
    check("bring_up2", {init_done, init_busy}, 2'b10);
    // LED update from DONE
    led_state = 3'b010;
    tick();
    check("upd_cmd", {tx_valid, tx_byte, init_done, init_busy}, 11'b1_11101101_1_1);
    tick();
    send_rx(8'hFA);
    check("upd_val", {tx_valid, tx_byte, init_done, init_busy}, 11'b1_00000010_1_1);
    tick();
    check("upd_busy", {init_done, init_busy}, 2'b11);
    send_rx(8'hFA);
    check("upd_done", {init_done, init_busy}, 2'b10);
    // random soak
    for (int i = 0; i < 3000; i++) begin
      tx_ready = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 4);
      rx_valid = $urandom_range(0, 3) == 0;
      rx_byte = r == 4 ? 8'($urandom) : pick[r];
      reset_required = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 99) == 0) led_state = 3'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
